// File: rtl/riscv_isa_pkg.sv
// RISC-V ISA constants used by the load/store datapath: opcodes, funct3 encodings
// and the alignment rule shared by the memory port and anything else that checks it.
package riscv_isa_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // funct3[1:0] encodes access size for both loads and stores
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uarch_pkg.sv
// Microarchitectural types shared between the LSQ, the memory port and the CDB.
package uarch_pkg;

    localparam int TAG_WIDTH = 6;

    typedef struct packed {
        logic [6:0]           opcode;
        logic [2:0]           funct3;
        logic [TAG_WIDTH-1:0] dest_tag;
        logic [31:0]          addr;
        logic [31:0]          st_data;
    } instruction_t;

    typedef struct packed {
        logic                 is_valid;
        logic [TAG_WIDTH-1:0] dest_tag;
        logic [31:0]          result;
    } writeback_packet_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        RESP,
        DRAIN
    } lsu_state_e;

endpackage

// File: rtl/lsu_mem_port_lane_align.sv
// Byte-lane steering for a 32-bit word memory: store strobes/data on the way out,
// sign/zero extension of the selected byte or half on the way back.
module lsu_lane_align
    import riscv_isa_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misalign,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_result
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        wstrb    = '0;
        wdata    = '0;
        misalign = is_misaligned(st_funct3, st_off);
        case (st_funct3)
            F3_SB: begin
                wstrb = 4'b0001 << st_off;
                wdata = {4{st_data[7:0]}};
            end
            F3_SH: begin
                wstrb = 4'b0011 << st_off;
                wdata = {2{st_data[15:0]}};
            end
            default: begin
                wstrb = 4'hF;
                wdata = st_data;
            end
        endcase
    end

    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_funct3)
            F3_LB:   ld_result = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_result = {24'b0, ld_byte};
            F3_LH:   ld_result = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_result = {16'b0, ld_half};
            default: ld_result = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-outstanding memory port between the LSQ execute port and the data memory;
// loads return on a dedicated CDB writeback port, stores complete silently.
module lsu_mem_port
    import riscv_isa_pkg::*;
    import uarch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              exec_valid,
    input  instruction_t      execute_pkt,
    output logic              alu_rdy,
    output logic              cache_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output writeback_packet_t wb_pkt,
    input  logic              wb_ack
);

    lsu_state_e state_q, state_d;

    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 we_q, we_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [1:0]           off_q, off_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    result_q, result_d;
    logic                 granted_q, granted_d;

    logic        pkt_is_store;
    logic        pkt_misalign;
    logic        accept;
    logic [3:0]  pkt_wstrb;
    logic [31:0] pkt_wdata;
    logic [31:0] ld_result;

    assign pkt_is_store = (execute_pkt.opcode == OPC_STORE);
    assign accept       = exec_valid && !flush;

    lsu_lane_align u_align (
        .st_funct3 (execute_pkt.funct3),
        .st_off    (execute_pkt.addr[1:0]),
        .st_data   (execute_pkt.st_data),
        .wstrb     (pkt_wstrb),
        .wdata     (pkt_wdata),
        .misalign  (pkt_misalign),
        .ld_funct3 (funct3_q),
        .ld_off    (off_q),
        .rdata     (dmem_rdata),
        .ld_result (ld_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            funct3_q  <= '0;
            off_q     <= '0;
            tag_q     <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            result_q  <= '0;
            granted_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            we_q      <= we_d;
            funct3_q  <= funct3_d;
            off_q     <= off_d;
            tag_q     <= tag_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
            result_q  <= result_d;
            granted_q <= granted_d;
        end
    end

    // Stores are never cancelled by flush; only loads divert into DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (pkt_misalign) state_d = pkt_is_store ? IDLE : RESP;
                    else              state_d = REQ;
                end
            end
            REQ: begin
                if (flush && !we_q)  state_d = DRAIN;
                else if (dmem_gnt)   state_d = WAIT;
            end
            WAIT: begin
                if (dmem_rvalid)         state_d = (we_q || flush) ? IDLE : RESP;
                else if (flush && !we_q) state_d = DRAIN;
            end
            RESP: begin
                if (flush || wb_ack) state_d = IDLE;
            end
            DRAIN: begin
                if (granted_q && dmem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d    = addr_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        off_d     = off_q;
        tag_d     = tag_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        result_d  = result_q;
        granted_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d   = {execute_pkt.addr[ADDR_W-1:2], 2'b00};
                    we_d     = pkt_is_store;
                    funct3_d = execute_pkt.funct3;
                    off_d    = execute_pkt.addr[1:0];
                    tag_d    = execute_pkt.dest_tag;
                    wstrb_d  = pkt_is_store ? pkt_wstrb : '0;
                    wdata_d  = pkt_is_store ? pkt_wdata : '0;
                    result_d = '0;
                end
            end
            REQ:   granted_d = dmem_gnt;
            WAIT: begin
                granted_d = 1'b1;
                if (dmem_rvalid && !we_q) result_d = ld_result;
            end
            DRAIN: granted_d = granted_q || dmem_gnt;
            default: ;
        endcase
    end

    always_comb begin
        alu_rdy     = (state_q == IDLE);
        cache_stall = (state_q == REQ) || (state_q == WAIT) || (state_q == DRAIN);
        dmem_req    = (state_q == REQ) || ((state_q == DRAIN) && !granted_q);
        dmem_we     = dmem_req && we_q;
        dmem_addr   = dmem_req ? addr_q  : '0;
        dmem_wdata  = dmem_req ? wdata_q : '0;
        dmem_wstrb  = dmem_req ? wstrb_q : '0;
        wb_pkt      = '0;
        if (state_q == RESP) begin
            wb_pkt.is_valid = 1'b1;
            wb_pkt.dest_tag = tag_q;
            wb_pkt.result   = result_q;
        end
    end

    // IDLE is excluded: a reset mid-access can legitimately leave a response in flight.
    assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q == REQ) || (state_q == RESP)) |-> !dmem_rvalid);

endmodule
